// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: sequencing controller for a 4-tap, 6-bit convolution.
// Holds four tap weights and a 4-sample sliding window fed by a valid/ready
// stream. Each accepted sample (once the window is full) triggers four MAC
// cycles on a single shared 6x6 multiplier. Each result is emitted with its
// sample index. The block also tracks the running maximum and where it occurred.
module conv_scan_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [5:0]  cfg_data,
  input  logic        clear,
  input  logic        s_valid,
  input  logic [5:0]  s_data,
  output logic        s_ready,
  output logic        busy,
  output logic        r_valid,
  output logic [13:0] r_data,
  output logic [7:0]  r_index,
  output logic        max_valid,
  output logic [13:0] max_value,
  output logic [7:0]  max_index
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [5:0]  r_w   [4];
  logic [5:0]  r_win [4];   // r_win[0] holds the newest sample
  logic [1:0]  r_fill;
  logic [1:0]  r_k;
  logic [7:0]  r_idx;
  logic [7:0]  r_cur_index;
  logic [13:0] r_acc;

  logic        r_res_valid;
  logic [13:0] r_res_data;
  logic [7:0]  r_res_index;
  logic        r_max_valid;
  logic [13:0] r_max_value;
  logic [7:0]  r_max_index;

  logic        w_accept;
  logic [11:0] w_prod;
  logic [13:0] w_sum;
  logic        w_last;

  // The single shared multiplier. On the k==3 cycle, w_sum is the final dot product.
  // Its maximum value is 4*63*63 = 15876, so 14 bits cannot overflow.
  assign w_accept = s_valid && s_ready;
  assign w_prod   = r_w[r_k] * r_win[r_k];
  assign w_sum    = r_acc + 14'(w_prod);
  assign w_last   = (r_state == ST_MAC) && (r_k == 2'd3);

  assign s_ready   = (r_state == ST_IDLE) && !clear;
  assign busy      = (r_state == ST_MAC);
  assign r_valid   = r_res_valid;
  assign r_data    = r_res_data;
  assign r_index   = r_res_index;
  assign max_valid = r_max_valid;
  assign max_value = r_max_value;
  assign max_index = r_max_index;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: clear aborts to IDLE. A full-window accept starts the MAC.
  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept && (r_fill == 2'd3)) w_next_state = ST_MAC;
        ST_MAC:  if (r_k == 2'd3)                  w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Tap weights: writable only in IDLE. Weights survive clear.
  // NOTE: the weight array is small and architecturally defined at reset, so it is reset
  // explicitly rather than left as an uninitialised memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_w[i] <= '0;
    end else if (cfg_we && (r_state == ST_IDLE)) begin
      r_w[cfg_idx] <= cfg_data;
    end
  end

  // Window shift, index counting, MAC accumulation, and result/max registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
      r_fill      <= '0;
      r_k         <= '0;
      r_idx       <= '0;
      r_cur_index <= '0;
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_index <= '0;
      r_max_valid <= 1'b0;
      r_max_value <= '0;
      r_max_index <= '0;
    end else if (clear) begin
      // r_data and r_index keep their last values. Only the pulse is killed.
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
      r_fill      <= '0;
      r_k         <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_max_valid <= 1'b0;
      r_max_value <= '0;
      r_max_index <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_win[3]    <= r_win[2];
            r_win[2]    <= r_win[1];
            r_win[1]    <= r_win[0];
            r_win[0]    <= s_data;
            r_cur_index <= r_idx;
            r_idx       <= r_idx + 8'd1;
            if (r_fill != 2'd3) begin
              r_fill <= r_fill + 2'd1;
            end else begin
              r_acc <= '0;
              r_k   <= '0;
            end
          end
        end
        ST_MAC: begin
          r_acc <= w_sum;
          r_k   <= r_k + 2'd1;
          if (w_last) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum;
            r_res_index <= r_cur_index;
            // Strictly greater: on a tie the earlier index is kept.
            if (!r_max_valid || (w_sum > r_max_value)) begin
              r_max_valid <= 1'b1;
              r_max_value <= w_sum;
              r_max_index <= r_cur_index;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed self-checking bench for conv_scan_ctrl.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_conv_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [5:0]  cfg_data;
  logic        clear;
  logic        s_valid;
  logic [5:0]  s_data;
  logic        s_ready;
  logic        busy;
  logic        r_valid;
  logic [13:0] r_data;
  logic [7:0]  r_index;
  logic        max_valid;
  logic [13:0] max_value;
  logic [7:0]  max_index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_data  (cfg_data),
    .clear     (clear),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .busy      (busy),
    .r_valid   (r_valid),
    .r_data    (r_data),
    .r_index   (r_index),
    .max_valid (max_valid),
    .max_value (max_value),
    .max_index (max_index)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [1:0] idx, input logic [5:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_weights(input logic [5:0] w0, w1, w2, w3);
    write_w(2'd0, w0);
    write_w(2'd1, w1);
    write_w(2'd2, w2);
    write_w(2'd3, w3);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Present one sample and hold it until the edge on which it is accepted.
  task automatic push(input logic [5:0] d);
    int n = 0;
    while (!s_ready && n < 20) begin step(); n++; end
    if (!s_ready) check("ready_timeout", 0, 1);
    s_valid = 1'b1; s_data = d;
    step();
    s_valid = 1'b0;
  endtask

  // Count the edges after the accept until r_valid is seen, with a bounded wait.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!r_valid && lat < 20) begin step(); lat++; end
    if (!r_valid) check("result_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int exp_rdy;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    clear = 1'b0; s_valid = 1'b0; s_data = '0;
    step(); step();
    rst_n = 1'b1;

    // Reset state
    check("rst_s_ready",   s_ready,   1);
    check("rst_busy",      busy,      0);
    check("rst_r_valid",   r_valid,   0);
    check("rst_r_data",    r_data,    0);
    check("rst_r_index",   r_index,   0);
    check("rst_max_valid", max_valid, 0);
    check("rst_max_value", max_value, 0);
    check("rst_max_index", max_index, 0);

    // Fill and basic result: 1+2+3+4 = 10 at index 3, four edges after the accept
    set_weights(6'd1, 6'd1, 6'd1, 6'd1);
    push(6'd1); check("fill1_no_result", r_valid, 0); check("fill1_idle", s_ready, 1);
    push(6'd2); check("fill2_no_result", r_valid, 0);
    push(6'd3); check("fill3_no_result", r_valid, 0);
    push(6'd4); check("fill4_busy", busy, 1);
    wait_result(lat);
    check("basic_latency",   lat,       4);
    check("basic_r_data",    r_data,    10);
    check("basic_r_index",   r_index,   3);
    check("basic_max_value", max_value, 10);
    check("basic_max_index", max_index, 3);
    check("basic_max_valid", max_valid, 1);
    check("basic_ready_with_result", s_ready, 1);
    step();
    check("basic_pulse_one_cycle", r_valid, 0);
    check("basic_r_data_hold",     r_data,  10);

    // Tap ordering: w[0] multiplies the newest sample, w[3] the oldest
    do_clear();
    set_weights(6'd1, 6'd0, 6'd0, 6'd0);
    push(6'd5); push(6'd6); push(6'd7); push(6'd8);
    wait_result(lat);
    check("tap0_r_data",  r_data,  8);
    check("tap0_r_index", r_index, 3);
    set_weights(6'd0, 6'd0, 6'd0, 6'd1);
    push(6'd9);
    wait_result(lat);
    check("tap3_r_data",    r_data,    6);
    check("tap3_r_index",   r_index,   4);
    check("tap3_max_value", max_value, 8);
    check("tap3_max_index", max_index, 3);

    // Full scale: 4*63*63 = 15876
    do_clear();
    set_weights(6'd63, 6'd63, 6'd63, 6'd63);
    push(6'd63); push(6'd63); push(6'd63); push(6'd63);
    wait_result(lat);
    check("full_r_data",    r_data,    15876);
    check("full_max_value", max_value, 15876);

    // Tie and max tracking: 16 (idx 3), 16 (idx 4), 13 (idx 5); the max stays at idx 3
    do_clear();
    set_weights(6'd1, 6'd1, 6'd1, 6'd1);
    push(6'd4); push(6'd4); push(6'd4); push(6'd4);
    wait_result(lat);
    check("tie_a_r_data",  r_data,  16);
    check("tie_a_r_index", r_index, 3);
    push(6'd4);
    wait_result(lat);
    check("tie_b_r_data",  r_data,  16);
    check("tie_b_r_index", r_index, 4);
    push(6'd1);
    wait_result(lat);
    check("tie_c_r_data",    r_data,    13);
    check("tie_c_r_index",   r_index,   5);
    check("tie_max_value",   max_value, 16);
    check("tie_max_index",   max_index, 3);

    // Handshake: s_valid held high with a full window gives s_ready 1,0,0,0,0 repeating
    s_valid = 1'b1; s_data = 6'd2;
    for (int i = 0; i < 10; i++) begin
      exp_rdy = (i % 5 == 0) ? 1 : 0;
      check($sformatf("hs_ready_%0d", i), s_ready, exp_rdy);
      step();
    end
    s_valid = 1'b0;
    // The two accepted samples give windows {2,1,4,4}=11 and {2,2,1,4}=9.
    check("hs_r_valid", r_valid, 1);
    check("hs_r_data",  r_data,  9);
    check("hs_r_index", r_index, 7);
    check("hs_max_kept", max_value, 16);

    // Abort: clear two cycles after the 4th accept suppresses the result
    do_clear();
    push(6'd1); push(6'd1); push(6'd1); push(6'd1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (r_valid) seen++;
      step();
    end
    check("abort_no_result", seen, 0);
    check("abort_max_valid", max_valid, 0);
    check("abort_idle",      s_ready,   1);
    push(6'd2); check("abort_refill1", r_valid | busy, 0);
    push(6'd3); check("abort_refill2", r_valid | busy, 0);
    push(6'd4); check("abort_refill3", r_valid | busy, 0);
    push(6'd5);
    wait_result(lat);
    check("abort_r_index",     r_index, 3);
    check("abort_weights_kept", r_data, 14);

    // A weight write during MAC is ignored: {10,5,4,3}=22, then {1,10,5,4}=20
    push(6'd10);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = 6'd0;
    step(); step();
    cfg_we = 1'b0;
    wait_result(lat);
    check("busy_write_r_data", r_data, 22);
    push(6'd1);
    wait_result(lat);
    check("busy_write_next_r_data",  r_data,  20);
    check("busy_write_next_r_index", r_index, 5);

    // Index wrap: 258 samples give sample indices 0..255, 0, 1
    do_clear();
    for (int i = 0; i < 258; i++) begin
      push(6'd1);
      if (i >= 3) begin
        wait_result(lat);
        if (i == 255) check("wrap_idx_255", r_index, 255);
        if (i == 256) check("wrap_idx_0",   r_index, 0);
        if (i == 257) begin
          check("wrap_idx_1",  r_index, 1);
          check("wrap_r_data", r_data,  4);
        end
      end
    end
    check("wrap_max_index", max_index, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
